// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the two-requester multiplier arbiter.
// Operand/result widths and the request-FSM state encoding live here.
package mult_arb_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: the requester not served last wins a tie.
// Grant is one-hot, or zero when nobody requests.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier between two requesters with round-robin grant,
// a bounded wait for completion and a held response handshake.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [OP_W-1:0]  num_1_0,
  input  logic [OP_W-1:0]  num_2_0,
  input  logic [OP_W-1:0]  num_1_1,
  input  logic [OP_W-1:0]  num_2_1,
  output logic             mult_valid,
  output logic [OP_W-1:0]  mult_num_1,
  output logic [OP_W-1:0]  mult_num_2,
  input  logic             mult_done,
  input  logic [RES_W-1:0] mult_result,
  input  logic             mult_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_sign,
  output logic             rsp_timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_n;
  logic             last, id_q;
  logic [OP_W-1:0]  op1_q, op2_q;
  logic [RES_W-1:0] res_q;
  logic             sign_q, to_q;
  logic [CW-1:0]    cnt;
  logic [1:0]       grant;
  logic             accept, done_hit, to_hit, rsp_hs;

  rr_arbiter_2 u_arb (
    .req   (req_valid),
    .last  (last),
    .grant (grant)
  );

  assign accept   = (state == IDLE) && (grant != 2'b00) && !rst;
  assign done_hit = (state == WAIT) && mult_done;
  assign to_hit   = (state == WAIT) && !mult_done
                  && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_hs   = (state == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (done_hit || to_hit) state_n = RESP;
      RESP:    if (rsp_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      id_q   <= 1'b0;
      op1_q  <= '0;
      op2_q  <= '0;
      res_q  <= '0;
      sign_q <= 1'b0;
      to_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        id_q  <= grant[1];
        op1_q <= grant[1] ? num_1_1 : num_1_0;
        op2_q <= grant[1] ? num_2_1 : num_2_0;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      // completion beats the timeout when both land together
      if (done_hit) begin
        res_q  <= mult_result;
        sign_q <= mult_sign;
        to_q   <= 1'b0;
      end else if (to_hit) begin
        res_q  <= '0;
        sign_q <= 1'b0;
        to_q   <= 1'b1;
      end
      if (rsp_hs) last <= id_q;
    end
  end

  assign req_ready   = (state == IDLE && !rst) ? grant : 2'b00;
  assign mult_valid  = (state == ISSUE) && !rst;
  assign rsp_valid   = (state == RESP) && !rst;
  assign mult_num_1  = rst ? '0 : op1_q;
  assign mult_num_2  = rst ? '0 : op2_q;
  assign rsp_id      = !rst && id_q;
  assign rsp_result  = rst ? '0 : res_q;
  assign rsp_sign    = !rst && sign_q;
  assign rsp_timeout = !rst && to_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: timestamp-based transaction model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mult_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [7:0]  num_1_0, num_2_0, num_1_1, num_2_1;
  logic        mult_valid;
  logic [7:0]  mult_num_1, mult_num_2;
  logic        mult_done;
  logic [15:0] mult_result;
  logic        mult_sign;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_sign, rsp_timeout;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .num_1_0(num_1_0), .num_2_0(num_2_0),
    .num_1_1(num_1_1), .num_2_1(num_2_1),
    .mult_valid(mult_valid),
    .mult_num_1(mult_num_1), .mult_num_2(mult_num_2),
    .mult_done(mult_done), .mult_result(mult_result),
    .mult_sign(mult_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_sign(rsp_sign), .rsp_timeout(rsp_timeout)
  );

  // transaction model: timestamps of acceptance and response
  int         cyc    = 0;
  bit         m_busy = 0;
  int         m_acc  = 0;
  int         m_rsp  = -1;
  bit         m_id   = 0;
  bit         m_last = 1;
  logic [7:0] m_op1  = '0, m_op2 = '0;
  logic [15:0] m_res = '0;
  bit         m_sign = 0, m_to = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic logic [1:0] pick(logic [1:0] v, bit l);
    if (v == 2'b11) return l ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic model_cycle();
    logic [1:0] g;
    bit in_resp;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mult_valid", mult_valid, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_num1", mult_num_1, 0);
      chk("rst_num2", mult_num_2, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_sign", rsp_sign, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      m_busy = 0; m_last = 1; m_rsp = -1;
      m_op1 = '0; m_op2 = '0;
    end else begin
      g = m_busy ? 2'b00 : pick(req_valid, m_last);
      in_resp = m_busy && m_rsp >= 0 && cyc >= m_rsp;
      chk("req_ready", req_ready, g);
      chk("mult_valid", mult_valid, m_busy && cyc == m_acc + 1);
      chk("rsp_valid", rsp_valid, in_resp);
      if (m_busy && !in_resp && cyc > m_acc) begin
        chk("mult_num_1", mult_num_1, m_op1);
        chk("mult_num_2", mult_num_2, m_op2);
      end
      if (in_resp) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_sign", rsp_sign, m_sign);
        chk("rsp_timeout", rsp_timeout, m_to);
      end
      if (g != 2'b00) begin
        m_busy = 1; m_acc = cyc; m_rsp = -1; m_id = g[1];
        m_op1 = g[1] ? num_1_1 : num_1_0;
        m_op2 = g[1] ? num_2_1 : num_2_0;
      end else if (m_busy && m_rsp < 0 && cyc >= m_acc + 2) begin
        if (mult_done) begin
          m_res = mult_result; m_sign = mult_sign; m_to = 0;
          m_rsp = cyc + 1;
        end else if (cyc == m_acc + 1 + TO) begin
          m_res = '0; m_sign = 0; m_to = 1;
          m_rsp = cyc + 1;
        end
      end else if (in_resp && rsp_ready) begin
        m_busy = 0; m_last = m_id;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; mult_done = 0; rsp_ready = 0;
    step(); step();
    rst = 0;
  endtask

  logic [1:0] grants[$];
  logic [1:0] r;
  int t_mv, t_rv;

  initial begin
    rst = 1; req_valid = 0; mult_done = 0; rsp_ready = 0;
    num_1_0 = 0; num_2_0 = 0; num_1_1 = 0; num_2_1 = 0;
    mult_result = 0; mult_sign = 0;
    req_valid = 2'b11;
    #1 chk("rst_ready_gated", req_ready, 0);
    do_reset();

    // single request from requester 0
    req_valid = 2'b01; num_1_0 = 8'h05; num_2_0 = 8'h03;
    #1 chk("t1_ready", req_ready, 2'b01);
    step();
    req_valid = 0;
    #1 chk("t1_mult_valid", mult_valid, 1);
    chk("t1_num1", mult_num_1, 8'h05);
    chk("t1_num2", mult_num_2, 8'h03);
    step();
    mult_done = 1; mult_result = 16'd15; mult_sign = 0;
    step();
    mult_done = 0;
    #1 chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_result", rsp_result, 16'd15);
    chk("t1_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1; step(); rsp_ready = 0;

    // both requesters continuously valid
    do_reset();
    req_valid = 2'b11; mult_done = 1; rsp_ready = 1;
    for (int i = 0; i < 100 && grants.size() < 4; i++) begin
      num_1_0 = 8'($urandom_range(0, 255));
      num_1_1 = 8'($urandom_range(0, 255));
      mult_result = 16'($urandom_range(0, 65535));
      #1 if (req_ready != 2'b00) grants.push_back(req_ready);
      step();
    end
    chk("t2_grant_count", grants.size(), 4);
    while (grants.size() < 4) grants.push_back(2'b00);
    chk("t2_grant0", grants[0], 2'b01);
    chk("t2_grant1", grants[1], 2'b10);
    chk("t2_grant2", grants[2], 2'b01);
    chk("t2_grant3", grants[3], 2'b10);
    req_valid = 0;
    repeat (6) step();

    // multiplier never answers
    do_reset();
    req_valid = 2'b01; t_mv = -100; t_rv = -1;
    for (int i = 0; i < 60; i++) begin
      #1 if (mult_valid) t_mv = i;
      if (rsp_valid) begin t_rv = i; break; end
      r = req_ready;
      step();
      if (r != 2'b00) req_valid = 0;
    end
    chk("t3_timeout_latency", t_rv - t_mv, TO + 1);
    chk("t3_rsp_timeout", rsp_timeout, 1);
    chk("t3_rsp_result", rsp_result, 0);

    // response back-pressure with a second request pending
    req_valid = 2'b10; num_1_1 = 8'h21; num_2_1 = 8'h42;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t4_stall_ready", req_ready, 0);
      chk("t4_stall_valid", rsp_valid, 1);
      step();
    end
    rsp_ready = 1;
    #1 chk("t4_hs_ready", req_ready, 0);
    step();
    rsp_ready = 0;
    #1 chk("t4_second", req_ready, 2'b10);
    step();
    req_valid = 0; mult_done = 1; rsp_ready = 1;
    repeat (6) step();
    mult_done = 0; rsp_ready = 0;

    // reset mid-WAIT, then a stale completion
    do_reset();
    req_valid = 2'b01; step();
    req_valid = 0; step(); step(); step();
    rst = 1; step(); rst = 0;
    mult_done = 1; mult_result = 16'h1234; step();
    mult_done = 0;
    #1 chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_mult_valid", mult_valid, 0);
    chk("t5_rsp_result", rsp_result, 0);
    req_valid = 2'b01;
    #1 chk("t5_idle", req_ready, 2'b01);
    req_valid = 0; step();

    // completion on the timeout cycle
    do_reset();
    req_valid = 2'b01; step();
    req_valid = 0; step();
    repeat (TO - 1) step();
    mult_done = 1; mult_result = 16'hBEEF; mult_sign = 1; step();
    mult_done = 0;
    #1 chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_timeout", rsp_timeout, 0);
    chk("t6_result", rsp_result, 16'hBEEF);
    chk("t6_sign", rsp_sign, 1);
    rsp_ready = 1; step(); rsp_ready = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_valid = 2'($urandom_range(0, 3));
      num_1_0 = 8'($urandom_range(0, 255));
      num_2_0 = 8'($urandom_range(0, 255));
      num_1_1 = 8'($urandom_range(0, 255));
      num_2_1 = 8'($urandom_range(0, 255));
      mult_done = ($urandom_range(0, 11) == 0);
      mult_result = 16'($urandom_range(0, 65535));
      mult_sign = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
